// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
//
// Shared types for the single-command Wishbone B4 classic master.
//   wb_master_state_t : bus-cycle controller states
//   wb_phase_t        : progress through a read-modify-write command
// -----------------------------------------------------------------------------
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // waiting for a command, cmd_ready_o high
        STROBE = 2'd1,  // stb_o high, waiting for ack_i / err_i / timeout
        GAP    = 2'd2,  // RMW only: one stb_o-low cycle with cyc_o held
        RESP   = 2'd3   // response presented, waiting for rsp_ready_i
    } wb_master_state_t;

    typedef enum logic {
        PHASE_READ  = 1'b0,
        PHASE_WRITE = 1'b1
    } wb_phase_t;

endpackage : wb_pkg

// File: rtl/wb_timeout_counter.sv
// -----------------------------------------------------------------------------
// wb_timeout_counter
//
// Counts cycles in which a strobe is outstanding and unanswered. 'expired'
// is combinational and rises in the TIMEOUT-th counted cycle, so the
// controller can close the cycle on that same edge and stb_o ends up high
// for exactly TIMEOUT cycles. TIMEOUT = 0 never expires.
//
// Ports:
//   clk_i   in  clock
//   rst_i   in  asynchronous active-high reset (count -> 0)
//   clear   in  force the count to 0 (held while not strobing)
//   enable  in  count this cycle (strobe high, no ack/err)
//   expired out this is the last allowed unanswered cycle
// -----------------------------------------------------------------------------
module wb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
    localparam logic [CW-1:0] C_MAX = '1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the block leaves it unassigned and infers a latch.
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != C_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: asynchronous reset is in the sensitivity list; state updates use
    // non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (count_q == LAST);

endmodule : wb_timeout_counter

// File: rtl/wb_master_single.sv
// -----------------------------------------------------------------------------
// wb_master_single
//
// Wishbone B4 classic-cycle master executing one local command at a time as
// a SINGLE READ, SINGLE WRITE or READ-MODIFY-WRITE. Every command returns
// exactly one response (read data + error flag). Unanswered strobes are
// bounded by a timeout so a missing slave cannot hang the local side.
//
// Parameters:
//   ADDR_WIDTH, DATA_WIDTH, GRANULE (select granularity), TIMEOUT (0 = off)
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o    command handshake (ready only in IDLE)
//   cmd_adr_i, cmd_dat_i         address, write / RMW insert data
//   cmd_mask_i                   RMW bit mask (1 = take cmd_dat_i bit)
//   cmd_sel_i, cmd_we_i          granule select, write enable
//   cmd_rmw_i                    read-modify-write (overrides cmd_we_i)
//   rsp_valid_o / rsp_ready_i    response handshake, held until consumed
//   rsp_dat_o, rsp_err_o         read data (old value for RMW), error
//   adr_o, dat_o, sel_o, we_o,
//   cyc_o, stb_o                 Wishbone master outputs (all registered)
//   dat_i, ack_i, err_i          Wishbone master inputs
// -----------------------------------------------------------------------------
module wb_master_single
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int GRANULE    = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]         cmd_adr_i,
    input  logic [DATA_WIDTH-1:0]         cmd_dat_i,
    input  logic [DATA_WIDTH-1:0]         cmd_mask_i,
    input  logic [DATA_WIDTH/GRANULE-1:0] cmd_sel_i,
    input  logic                          cmd_we_i,
    input  logic                          cmd_rmw_i,

    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [DATA_WIDTH-1:0]         rsp_dat_o,
    output logic                          rsp_err_o,

    output logic [ADDR_WIDTH-1:0]         adr_o,
    output logic [DATA_WIDTH-1:0]         dat_o,
    output logic [DATA_WIDTH/GRANULE-1:0] sel_o,
    output logic                          we_o,
    output logic                          cyc_o,
    output logic                          stb_o,
    input  logic [DATA_WIDTH-1:0]         dat_i,
    input  logic                          ack_i,
    input  logic                          err_i
);

    localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;

    wb_master_state_t        state_q,     state_d;
    wb_phase_t               phase_q,     phase_d;
    logic                    rmw_q,       rmw_d;
    logic [ADDR_WIDTH-1:0]   adr_q,       adr_d;
    logic [DATA_WIDTH-1:0]   dat_q,       dat_d;
    logic [DATA_WIDTH-1:0]   mask_q,      mask_d;
    logic [DATA_WIDTH-1:0]   old_q,       old_d;
    logic [SEL_WIDTH-1:0]    sel_q,       sel_d;
    logic                    we_q,        we_d;
    logic                    cyc_q,       cyc_d;
    logic                    stb_q,       stb_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_dat_q,   rsp_dat_d;
    logic                    rsp_err_q,   rsp_err_d;

    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;

    // Strobe cycles are the only ones that count; leaving STROBE (response,
    // GAP) clears the count, so each new stb_o rising edge starts from 0.
    assign tmo_clear  = (state_q != STROBE);
    assign tmo_enable = (state_q == STROBE) && !ack_i && !err_i;

    wb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // Combinational on purpose: reset must block acceptance immediately.
    assign cmd_ready_o = (state_q == IDLE) && !rst_i;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        rmw_d       = rmw_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        mask_d      = mask_q;
        old_d       = old_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    adr_d     = cmd_adr_i;
                    sel_d     = cmd_sel_i;
                    dat_d     = cmd_dat_i;
                    mask_d    = cmd_mask_i;
                    rmw_d     = cmd_rmw_i;
                    // RMW always opens with the read half.
                    we_d      = cmd_rmw_i ? 1'b0 : cmd_we_i;
                    phase_d   = PHASE_READ;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    rsp_err_d = 1'b0;
                    state_d   = STROBE;
                end
            end

            STROBE: begin
                if (err_i) begin
                    // err_i outranks a simultaneous ack_i; an RMW read error
                    // therefore never reaches the write half.
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (ack_i) begin
                    if (rmw_q && (phase_q == PHASE_READ)) begin
                        // Keep the bus locked (cyc_o) across the two halves.
                        old_d   = dat_i;
                        dat_d   = (dat_i & ~mask_q) | (dat_q & mask_q);
                        stb_d   = 1'b0;
                        state_d = GAP;
                    end else begin
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        rsp_err_d   = 1'b0;
                        if (rmw_q) begin
                            rsp_dat_d = old_q;
                        end else if (we_q) begin
                            rsp_dat_d = '0;
                        end else begin
                            rsp_dat_d = dat_i;
                        end
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end else if (tmo_expired) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end

            GAP: begin
                // One full stb_o-low cycle lets a slave drop its ack first.
                we_d    = 1'b1;
                stb_d   = 1'b1;
                phase_d = PHASE_WRITE;
                state_d = STROBE;
            end

            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            phase_q     <= PHASE_READ;
            rmw_q       <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            mask_q      <= '0;
            old_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            rmw_q       <= rmw_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            mask_q      <= mask_d;
            old_q       <= old_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign sel_o       = sel_q;
    assign we_o        = we_q;
    assign cyc_o       = cyc_q;
    assign stb_o       = stb_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

endmodule : wb_master_single

// File: tb/tb_wb_master_single.sv
// -----------------------------------------------------------------------------
// tb_wb_master_single
//
// Drives wb_master_single (TIMEOUT=8) against a small 2-cycle-latency
// register slave, plus a second instance (TIMEOUT=0) with no slave at all.
// Expected responses are queued when a command is driven and compared when
// the response handshake completes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_master_single;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    // Main DUT signals
    logic          cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_rmw_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i, cmd_mask_i;
    logic [SW-1:0] cmd_sel_i;
    logic          rsp_valid_o, rsp_ready_i, rsp_err_o;
    logic [DW-1:0] rsp_dat_o;
    logic [AW-1:0] adr_o;
    logic [DW-1:0] dat_o, dat_i;
    logic [SW-1:0] sel_o;
    logic          we_o, cyc_o, stb_o, ack_i, err_i;

    // TIMEOUT=0 DUT signals (no slave attached)
    logic          cmd_valid_z, cmd_ready_z;
    logic          rsp_valid_z, rsp_err_z;
    logic [DW-1:0] rsp_dat_z, dat_o_z;
    logic [AW-1:0] adr_o_z;
    logic [SW-1:0] sel_o_z;
    logic          we_o_z, cyc_o_z, stb_o_z;

    wb_master_single #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_mask_i(cmd_mask_i),
        .cmd_sel_i(cmd_sel_i), .cmd_we_i(cmd_we_i), .cmd_rmw_i(cmd_rmw_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
        .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o), .we_o(we_o),
        .cyc_o(cyc_o), .stb_o(stb_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i)
    );

    wb_master_single #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT(0)
    ) dut_z (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_z), .cmd_ready_o(cmd_ready_z),
        .cmd_adr_i(16'h0100), .cmd_dat_i(32'h0), .cmd_mask_i(32'h0),
        .cmd_sel_i(4'hF), .cmd_we_i(1'b0), .cmd_rmw_i(1'b0),
        .rsp_valid_o(rsp_valid_z), .rsp_ready_i(1'b1),
        .rsp_dat_o(rsp_dat_z), .rsp_err_o(rsp_err_z),
        .adr_o(adr_o_z), .dat_o(dat_o_z), .sel_o(sel_o_z), .we_o(we_o_z),
        .cyc_o(cyc_o_z), .stb_o(stb_o_z),
        .dat_i(32'h0), .ack_i(1'b0), .err_i(1'b0)
    );

    // ------------------------------------------------------------------
    // Register slave: 16 words at 0x00..0x3C, acks on the 3rd strobe cycle,
    // silent at 0x40 and above. inj_err turns its ack into ack+err.
    // ------------------------------------------------------------------
    logic [DW-1:0] mem [16];
    logic [1:0]    scnt;
    logic          inj_err;

    assign dat_i = mem[adr_o[5:2]];

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack_i <= 1'b0;
            err_i <= 1'b0;
            scnt  <= 2'd0;
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (cyc_o && stb_o && !ack_i && !err_i && (adr_o < 16'h0040)) begin
            if (scnt == 2'd1) begin
                scnt  <= 2'd0;
                ack_i <= 1'b1;
                err_i <= inj_err;
                if (we_o && !inj_err) begin
                    for (int b = 0; b < SW; b++)
                        if (sel_o[b]) mem[adr_o[5:2]][8*b +: 8] <= dat_o[8*b +: 8];
                end
            end else begin
                scnt <= scnt + 2'd1;
            end
        end else begin
            ack_i <= 1'b0;
            err_i <= 1'b0;
            if (!stb_o) scnt <= 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Checking and scoreboard
    // ------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          err;
    } rsp_t;

    rsp_t sb_q[$];

    always @(negedge clk_i) begin
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("rsp_dat", 64'(rsp_dat_o), 64'(e.dat));
                check("rsp_err", 64'(rsp_err_o), 64'(e.err));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic          rmw;
        logic          we;
        logic          inj;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [DW-1:0] mask;
        logic [SW-1:0] sel;
        logic [DW-1:0] exp_dat;
        logic          exp_err;
        int            exp_cycles;  // accept edge -> first rsp_valid_o cycle
        int            exp_stb;     // cycles with stb_o high
        int            exp_gap;     // cycles with cyc_o high and stb_o low
    } vec_t;

    function automatic vec_t mk(input logic rmw, input logic we, input logic inj,
                                input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                                input logic [DW-1:0] mask, input logic [SW-1:0] sel,
                                input logic [DW-1:0] exp_dat, input logic exp_err,
                                input int exp_cycles, input int exp_stb, input int exp_gap);
        vec_t v;
        v.rmw = rmw; v.we = we; v.inj = inj; v.adr = adr; v.dat = dat;
        v.mask = mask; v.sel = sel; v.exp_dat = exp_dat; v.exp_err = exp_err;
        v.exp_cycles = exp_cycles; v.exp_stb = exp_stb; v.exp_gap = exp_gap;
        return v;
    endfunction

    task automatic wait_accept(input string name);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk_i);
            if (cmd_ready_o) acc = 1'b1;
        end
        if (!acc) check({name, "_accept_timeout"}, 64'd0, 64'd1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cycles, stb_n, gap_n, nocyc_n, adr_bad;
        bit seen;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(posedge clk_i); #1;
        inj_err     = v.inj;
        cmd_valid_i = 1'b1;
        cmd_rmw_i   = v.rmw;
        cmd_we_i    = v.we;
        cmd_adr_i   = v.adr;
        cmd_dat_i   = v.dat;
        cmd_mask_i  = v.mask;
        cmd_sel_i   = v.sel;
        sb_q.push_back('{dat: v.exp_dat, err: v.exp_err});
        wait_accept(tag);
        cycles = 0; stb_n = 0; gap_n = 0; nocyc_n = 0; adr_bad = 0; seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_i);
            cycles++;
            if (rsp_valid_o) begin
                seen = 1'b1;
            end else begin
                if (stb_o) stb_n++;
                if (cyc_o && !stb_o) gap_n++;
                if (!cyc_o) nocyc_n++;
                if (stb_o && ((adr_o != v.adr) || (sel_o != v.sel))) adr_bad++;
            end
        end
        check({tag, "_rsp_seen"},   64'(seen),    64'd1);
        check({tag, "_cycles"},     64'(cycles),  64'(v.exp_cycles));
        check({tag, "_stb_cycles"}, 64'(stb_n),   64'(v.exp_stb));
        check({tag, "_gap_cycles"}, 64'(gap_n),   64'(v.exp_gap));
        check({tag, "_cyc_drop"},   64'(nocyc_n), 64'd0);
        check({tag, "_adr_sel"},    64'(adr_bad), 64'd0);
        @(negedge clk_i);
        check({tag, "_ready_next"}, 64'(cmd_ready_o), 64'd1);
    endtask

    vec_t vecs[15];

    initial begin
        int stb_n;
        bit seen;

        vecs[0]  = mk(0, 1, 0, 16'h0010, 32'hDEADBEEF, 32'h0,        4'hF, 32'h0,        0, 4, 3, 0);
        vecs[1]  = mk(0, 0, 0, 16'h0010, 32'h0,        32'h0,        4'hF, 32'hDEADBEEF, 0, 4, 3, 0);
        vecs[2]  = mk(0, 1, 0, 16'h0014, 32'h12345678, 32'h0,        4'hF, 32'h0,        0, 4, 3, 0);
        vecs[3]  = mk(1, 0, 0, 16'h0014, 32'h0000AB00, 32'h0000FF00, 4'hF, 32'h12345678, 0, 8, 6, 1);
        vecs[4]  = mk(0, 0, 0, 16'h0014, 32'h0,        32'h0,        4'hF, 32'h1234AB78, 0, 4, 3, 0);
        vecs[5]  = mk(0, 1, 0, 16'h0018, 32'hAABBCCDD, 32'h0,        4'h3, 32'h0,        0, 4, 3, 0);
        vecs[6]  = mk(0, 0, 0, 16'h0018, 32'h0,        32'h0,        4'hF, 32'h0000CCDD, 0, 4, 3, 0);
        vecs[7]  = mk(0, 1, 0, 16'h0018, 32'h11223344, 32'h0,        4'h8, 32'h0,        0, 4, 3, 0);
        vecs[8]  = mk(0, 0, 0, 16'h0018, 32'h0,        32'h0,        4'hF, 32'h1100CCDD, 0, 4, 3, 0);
        vecs[9]  = mk(0, 1, 0, 16'h003C, 32'h5A5A5A5A, 32'h0,        4'hF, 32'h0,        0, 4, 3, 0);
        vecs[10] = mk(1, 0, 1, 16'h003C, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hF, 32'h0,        1, 4, 3, 0);
        vecs[11] = mk(0, 0, 0, 16'h003C, 32'h0,        32'h0,        4'hF, 32'h5A5A5A5A, 0, 4, 3, 0);
        vecs[12] = mk(0, 0, 0, 16'h0040, 32'h0,        32'h0,        4'hF, 32'h0,        1, 9, 8, 0);
        vecs[13] = mk(1, 1, 0, 16'h0010, 32'hFFFFFFFF, 32'h000000F0, 4'hF, 32'hDEADBEEF, 0, 8, 6, 1);
        vecs[14] = mk(0, 0, 0, 16'h0010, 32'h0,        32'h0,        4'hF, 32'hDEADBEFF, 0, 4, 3, 0);

        rst_i = 1'b1;
        cmd_valid_i = 1'b0; cmd_rmw_i = 1'b0; cmd_we_i = 1'b0;
        cmd_adr_i = '0; cmd_dat_i = '0; cmd_mask_i = '0; cmd_sel_i = '0;
        rsp_ready_i = 1'b1; inj_err = 1'b0; cmd_valid_z = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        check("rst_bus_out",   64'({cyc_o, stb_o, we_o, sel_o}), 64'd0);
        check("rst_adr_dat",   64'({adr_o, dat_o}), 64'd0);
        check("rst_rsp",       64'({rsp_valid_o, rsp_err_o, rsp_dat_o}), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_rst_ready", 64'(cmd_ready_o), 64'd1);

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);
        inj_err = 1'b0;

        // Response back-pressure: hold rsp_ready_i low for 10 cycles with a
        // second command already waiting.
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        cmd_valid_i = 1'b1; cmd_rmw_i = 1'b0; cmd_we_i = 1'b0;
        cmd_adr_i = 16'h0014; cmd_sel_i = 4'hF;
        sb_q.push_back('{dat: 32'h1234AB78, err: 1'b0});
        wait_accept("hold");
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen = 1'b1;
        end
        check("hold_rsp_seen", 64'(seen), 64'd1);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 16'h0020;
        cmd_dat_i = 32'h00000077; cmd_sel_i = 4'hF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            check("hold_valid", 64'(rsp_valid_o), 64'd1);
            check("hold_dat",   64'(rsp_dat_o),   64'h1234AB78);
            check("hold_ready", 64'(cmd_ready_o), 64'd0);
            check("hold_stb",   64'(stb_o),       64'd0);
        end
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b1;
        sb_q.push_back('{dat: 32'h0, err: 1'b0});
        wait_accept("hold2");
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) seen = 1'b1;
        end
        check("hold2_rsp_seen", 64'(seen), 64'd1);
        check("hold2_mem", 64'(mem[8]), 64'h00000077);

        // TIMEOUT=0: strobe stays up with no slave.
        @(posedge clk_i); #1;
        cmd_valid_z = 1'b1;
        @(negedge clk_i);
        check("tmo0_ready", 64'(cmd_ready_z), 64'd1);
        @(posedge clk_i); #1;
        cmd_valid_z = 1'b0;
        stb_n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_i);
            if (stb_o_z && cyc_o_z && !rsp_valid_z) stb_n++;
        end
        check("tmo0_stb_held", 64'(stb_n), 64'd60);

        // Reset in the middle of a strobe (silent address, no response queued).
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 16'h0040;
        wait_accept("rst_mid");
        repeat (3) @(negedge clk_i);
        check("rst_mid_stb_before", 64'(stb_o), 64'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check("rst_mid_cyc_stb", 64'({cyc_o, stb_o}), 64'd0);
        check("rst_mid_rsp",     64'(rsp_valid_o),    64'd0);
        check("rst_mid_ready",   64'(cmd_ready_o),    64'd0);
        check("rst_mid_z_stb",   64'(stb_o_z),        64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_rel_ready", 64'(cmd_ready_o), 64'd1);
        @(negedge clk_i);
        check("rst_rel_idle", 64'({cmd_ready_o, cyc_o, stb_o, rsp_valid_o}), 64'b1000);

        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wb_master_single

// File: doc/wb_master_single.md
# wb_master_single

Wishbone B4 classic-cycle master that turns single commands from a local valid/ready request port into SINGLE READ, SINGLE WRITE or READ-MODIFY-WRITE bus cycles. Each command returns one response carrying read data and an error flag. It sits between a local controller (CPU bridge, test sequencer) and a Wishbone interconnect or slave. Cycles are bounded by a timeout so a missing slave cannot hang the local side.

## Interface
- ADDR_WIDTH, 16, address width
- DATA_WIDTH, 32, data port width (8/16/32/64)
- GRANULE, 8, select granularity; SEL_WIDTH = DATA_WIDTH/GRANULE (localparam)
- TIMEOUT, 255, max cycles stb_o may stay high unanswered; 0 disables the timeout
- clk_i  in  1  clock; everything is sampled on the rising edge
- rst_i  in  1  asynchronous, active-high reset
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_adr_i  in  ADDR_WIDTH  target address
- cmd_dat_i  in  DATA_WIDTH  write data / RMW insert data
- cmd_mask_i  in  DATA_WIDTH  RMW bit mask (1 = take cmd_dat_i bit)
- cmd_sel_i  in  SEL_WIDTH  byte/granule select
- cmd_we_i  in  1  1 = write, 0 = read (ignored when cmd_rmw_i)
- cmd_rmw_i  in  1  read-modify-write
- rsp_valid_o  out  1  response present, held until rsp_ready_i
- rsp_ready_i  in  1  response consumed
- rsp_dat_o  out  DATA_WIDTH  read data (old value for RMW, 0 for write)
- rsp_err_o  out  1  err_i received or timeout
- adr_o, dat_o, sel_o, we_o, cyc_o, stb_o  out  (ADDR_WIDTH, DATA_WIDTH, SEL_WIDTH, 1, 1, 1)  Wishbone master outputs
- dat_i  in  DATA_WIDTH, ack_i  in  1, err_i  in  1  Wishbone master inputs

## Operation
- Reset: all Wishbone outputs, rsp_valid_o, rsp_err_o and rsp_dat_o are 0; state is IDLE; the timeout count is 0. cmd_ready_o is forced to 0 while rst_i is high.
- States are IDLE, STROBE, GAP and RESP. A phase flag (READ/WRITE) tracks progress in an RMW command.
- IDLE:
  - cmd_ready_o=1.
  - On accept, latch the command, drive adr_o/sel_o/we_o/dat_o, set cyc_o=stb_o=1 and enter STROBE.
  - Plain transfers use we_o=cmd_we_i. RMW starts with we_o=0.
- STROBE:
  - On err_i: drop cyc_o/stb_o, set rsp_err_o=1 and enter RESP. err_i wins over ack_i when both are high; an RMW read error skips the write.
  - On ack_i with a plain transfer: drop cyc_o/stb_o and enter RESP. For a read, rsp_dat_o=dat_i.
  - On ack_i in the RMW read phase: latch dat_i as old value, drop stb_o only (cyc_o stays 1), set dat_o=(old & ~mask)|(cmd_dat & mask) and enter GAP.
  - On ack_i in the RMW write phase: drop cyc_o/stb_o and enter RESP with rsp_dat_o=old value.
  - Timeout: the counter increments each STROBE cycle with no ack/err. At TIMEOUT it drops cyc_o/stb_o, sets rsp_err_o=1, rsp_dat_o=0 and enters RESP.
- GAP: lasts exactly one cycle with stb_o=0 and cyc_o=1. It then sets we_o=1, stb_o=1 and returns to STROBE in the WRITE phase with the timeout count cleared.
- RESP: rsp_valid_o=1. When rsp_ready_i=1, clear rsp_valid_o and return to IDLE. No new command is accepted until then.
- ack_i/err_i are ignored outside STROBE. The timeout count clears on every stb_o rising edge.
- sel_o and adr_o are identical in both RMW phases.

## Timing
- All outputs are registered except cmd_ready_o, which is (state==IDLE)&&!rst_i.
- Command accepted at edge N gives cyc_o/stb_o high in cycle N+1.
- ack_i sampled high at edge M gives stb_o low in cycle M+1; rsp_valid_o is high in cycle M+1 for a plain transfer.
- stb_o is low for at least one full cycle between any two strobes, so a slave that releases ack only after stb drops is served correctly.
- With a 2-cycle-latency slave: plain transfer is 4 cycles from accept to rsp_valid_o; RMW is 8.
- If rsp_ready_i is high in the first RESP cycle, the next command can be accepted 2 cycles after rsp_valid_o rises.
- Reset mid-cycle drops cyc_o/stb_o asynchronously and discards the pending response.

## Structure
- Package wb_pkg holds:
  - the state enum wb_master_state_t (IDLE, STROBE, GAP, RESP);
  - the phase enum wb_phase_t (PHASE_READ, PHASE_WRITE).
- Sub-module wb_timeout_counter: inputs clk_i, rst_i, clear, enable; output expired; parameter TIMEOUT, where 0 means never expire.

## Test plan
- Write 0xDEADBEEF, sel=4'hF to a 2-cycle register slave, then read the same address -> rsp_dat_o=0xDEADBEEF, rsp_err_o=0, 4 cycles per transfer.
- Register holds 0x12345678; RMW with dat=0x0000AB00, mask=0x0000FF00 -> register becomes 0x1234AB78, rsp_dat_o=0x12345678, cyc_o continuously high with one stb_o-low GAP cycle.
- No slave (ack_i=0), TIMEOUT=8 -> stb_o high exactly 8 cycles, then rsp_err_o=1, rsp_dat_o=0. With TIMEOUT=0 -> stb_o stays high indefinitely.
- err_i and ack_i both high on the RMW read -> rsp_err_o=1, no write strobe, register unchanged.
- rsp_ready_i held low 10 cycles -> rsp_valid_o and rsp_dat_o stable, cmd_ready_o=0 throughout, a new command waits until the response is consumed.
- rst_i asserted while stb_o is high -> cyc_o/stb_o low in the same cycle, rsp_valid_o=0, cmd_ready_o=1 on the first cycle after release.
